// File: rtl/masked_and_checker.sv
// Output-side self-check for masked AND gadgets: recombines shares, pipelines the expected
// product by LATENCY and counts pass/mismatch. Optional macro HALT_ON_ERR_EN stops on first error.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   S_IDLE  | waiting for start after reset
//   S_RUN   | accepting vectors until target issued, checking tails
//   S_DRAIN | no new vectors, checking in-flight entries until target
//   S_DONE  | results held, done=1, start restarts
module masked_and_checker #(
    parameter int NSHARES = 3,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_vec,
    input  logic               in_valid,
    input  logic [NSHARES-1:0] x_sh,
    input  logic [NSHARES-1:0] y_sh,
    input  logic [NSHARES-1:0] z_sh,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [CNT_W-1:0]   first_err_idx,
    output logic [NSHARES-1:0] first_err_z
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] checked;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] issued_nx;
    logic [CNT_W-1:0] checked_nx;

    logic xu, yu, zu, exp_bit;
    logic active, accept;
    logic chk_v, chk_e, chk_hit, mismatch, halt;

    assign xu      = ^x_sh;
    assign yu      = ^y_sh;
    assign zu      = ^z_sh;
    assign exp_bit = xu & yu;

    assign active     = (state == S_RUN) || (state == S_DRAIN);
    assign accept     = (state == S_RUN) && in_valid && (issued < target);
    assign chk_hit    = active && chk_v;
    assign mismatch   = chk_hit && (zu != chk_e);
    assign issued_nx  = issued + CNT_W'(accept);
    assign checked_nx = checked + CNT_W'(chk_hit);

`ifdef HALT_ON_ERR_EN
    assign halt = mismatch;
`else
    assign halt = 1'b0;
`endif

    // Expected-product pipeline; the tail entry lines up with the gadget's z output.
    generate
        if (LATENCY == 0) begin : g_nodly
            assign chk_v = accept;
            assign chk_e = exp_bit;
        end else begin : g_dly
            logic [LATENCY-1:0] dl_v;
            logic [LATENCY-1:0] dl_e;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dl_v <= '0;
                    dl_e <= '0;
                end else begin
                    for (int i = LATENCY - 1; i > 0; i--) begin
                        dl_v[i] <= dl_v[i-1];
                        dl_e[i] <= dl_e[i-1];
                    end
                    dl_v[0] <= accept;
                    dl_e[0] <= exp_bit;
                    if (halt) begin
                        dl_v <= '0;
                    end
                end
            end

            assign chk_v = dl_v[LATENCY-1];
            assign chk_e = dl_e[LATENCY-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass_cnt      <= '0;
            err_cnt       <= '0;
            first_err_idx <= '1;
            first_err_z   <= '0;
            issued        <= '0;
            checked       <= '0;
            target        <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state         <= S_RUN;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass_cnt      <= '0;
                        err_cnt       <= '0;
                        first_err_idx <= '1;
                        first_err_z   <= '0;
                        issued        <= '0;
                        checked       <= '0;
                        target        <= num_vec;
                    end
                end
                S_RUN, S_DRAIN: begin
                    issued  <= issued_nx;
                    checked <= checked_nx;
                    if (chk_hit) begin
                        if (mismatch) begin
                            if (err_cnt != '1) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                            // err_cnt only reaches zero again on restart, so it marks the first miss.
                            if (err_cnt == '0) begin
                                first_err_idx <= checked;
                                first_err_z   <= z_sh;
                            end
                        end else begin
                            pass_cnt <= pass_cnt + 1'b1;
                        end
                    end
                    if (halt || ((state == S_DRAIN) && (checked_nx >= target))) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if ((state == S_RUN) && (issued_nx >= target)) begin
                        state <= S_DRAIN;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_masked_and_checker.sv
// Directed bench for masked_and_checker (NSHARES=3, LATENCY=1): z shares trail x/y by one cycle.
`timescale 1ns/1ps
module tb_masked_and_checker;

    localparam int NSHARES = 3;
    localparam int LATENCY = 1;
    localparam int CNT_W   = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [CNT_W-1:0]   num_vec;
    logic               in_valid;
    logic [NSHARES-1:0] x_sh, y_sh, z_sh;
    logic               busy, done;
    logic [CNT_W-1:0]   pass_cnt, err_cnt, first_err_idx;
    logic [NSHARES-1:0] first_err_z;

    logic [NSHARES-1:0] vx [8];
    logic [NSHARES-1:0] vy [8];
    logic [NSHARES-1:0] vz [8];

    int checks   = 0;
    int failures = 0;

    masked_and_checker #(.NSHARES(NSHARES), .LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_vec      (num_vec),
        .in_valid     (in_valid),
        .x_sh         (x_sh),
        .y_sh         (y_sh),
        .z_sh         (z_sh),
        .busy         (busy),
        .done         (done),
        .pass_cnt     (pass_cnt),
        .err_cnt      (err_cnt),
        .first_err_idx(first_err_idx),
        .first_err_z  (first_err_z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setv(input int i, input logic [2:0] x, input logic [2:0] y, input logic [2:0] z);
        vx[i] = x;
        vy[i] = y;
        vz[i] = z;
    endtask

    // Pulse start, then drive n_drive vectors with z lagging one cycle; optional start pulse mid-run.
    task automatic run_vecs(input int n_drive, input logic [CNT_W-1:0] nv, input int mid_start);
        start   = 1'b1;
        num_vec = nv;
        tick();
        start = 1'b0;
        for (int i = 0; i <= n_drive; i++) begin
            in_valid = (i < n_drive);
            x_sh     = (i < n_drive) ? vx[i] : '0;
            y_sh     = (i < n_drive) ? vy[i] : '0;
            z_sh     = (i > 0) ? vz[i-1] : '0;
            start    = (i == mid_start);
            if (i == mid_start) num_vec = 16'd1;
            tick();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        x_sh     = '0;
        y_sh     = '0;
        z_sh     = '0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; num_vec = '0; in_valid = 1'b0;
        x_sh = '0; y_sh = '0; z_sh = '0;
        tick(); tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass", {16'd0, pass_cnt}, 32'd0);
        check("rst_err", {16'd0, err_cnt}, 32'd0);
        check("rst_idx", {16'd0, first_err_idx}, 32'hFFFF);
        check("rst_z", {29'd0, first_err_z}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Four correct vectors: xu/yu = 1/1, 1/0, 0/1, 0/0
        setv(0, 3'b001, 3'b111, 3'b010);
        setv(1, 3'b100, 3'b101, 3'b110);
        setv(2, 3'b110, 3'b010, 3'b000);
        setv(3, 3'b000, 3'b011, 3'b101);
        run_vecs(4, 16'd4, -1);
        check("t1_done_on_last", {31'd0, done}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_pass", {16'd0, pass_cnt}, 32'd4);
        check("t1_err", {16'd0, err_cnt}, 32'd0);
        check("t1_idx", {16'd0, first_err_idx}, 32'hFFFF);
        check("t1_z", {29'd0, first_err_z}, 32'd0);

        // Vector 1 bad; a start pulse mid-run (num_vec=1) must be ignored
        setv(0, 3'b001, 3'b001, 3'b111);
        setv(1, 3'b011, 3'b111, 3'b001);
        setv(2, 3'b111, 3'b100, 3'b001);
        run_vecs(3, 16'd3, 1);
        wait_done("t2_done");
        check("t2_pass", {16'd0, pass_cnt}, 32'd2);
        check("t2_err", {16'd0, err_cnt}, 32'd1);
        check("t2_idx", {16'd0, first_err_idx}, 32'd1);
        check("t2_z", {29'd0, first_err_z}, 32'b001);

        // num_vec = 0
        start = 1'b1; num_vec = 16'd0;
        tick();
        start = 1'b0;
        check("t3_busy_run", {31'd0, busy}, 32'd1);
        check("t3_done_c1", {31'd0, done}, 32'd0);
        tick();
        check("t3_done_c2", {31'd0, done}, 32'd0);
        tick();
        check("t3_done_c3", {31'd0, done}, 32'd1);
        check("t3_pass", {16'd0, pass_cnt}, 32'd0);
        check("t3_err", {16'd0, err_cnt}, 32'd0);

        // num_vec = 2, in_valid held 5 cycles; extras would mismatch if checked
        setv(0, 3'b001, 3'b001, 3'b001);
        setv(1, 3'b000, 3'b000, 3'b000);
        for (int i = 2; i < 5; i++) setv(i, 3'b001, 3'b001, 3'b000);
        run_vecs(5, 16'd2, -1);
        wait_done("t4_done");
        check("t4_pass", {16'd0, pass_cnt}, 32'd2);
        check("t4_err", {16'd0, err_cnt}, 32'd0);

        // Reset after 2 of 5 vectors
        setv(0, 3'b001, 3'b111, 3'b010);
        setv(1, 3'b100, 3'b101, 3'b110);
        setv(2, 3'b110, 3'b010, 3'b000);
        setv(3, 3'b000, 3'b011, 3'b101);
        setv(4, 3'b111, 3'b001, 3'b100);
        start = 1'b1; num_vec = 16'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; x_sh = vx[i]; y_sh = vy[i];
            z_sh = (i > 0) ? vz[i-1] : '0;
            tick();
        end
        check("t5_pre_pass", {16'd0, pass_cnt}, 32'd1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_pass", {16'd0, pass_cnt}, 32'd0);
        check("t5_rst_idx", {16'd0, first_err_idx}, 32'hFFFF);
        tick();
        rst_n = 1'b1;
        tick();
        run_vecs(5, 16'd5, -1);
        wait_done("t5_done");
        check("t5_pass", {16'd0, pass_cnt}, 32'd5);
        check("t5_err", {16'd0, err_cnt}, 32'd0);

        // num_vec = 6, vector 2 bad
        setv(0, 3'b001, 3'b111, 3'b100);
        setv(1, 3'b010, 3'b000, 3'b000);
        setv(2, 3'b111, 3'b111, 3'b011);
        setv(3, 3'b011, 3'b001, 3'b011);
        setv(4, 3'b101, 3'b110, 3'b000);
        setv(5, 3'b100, 3'b010, 3'b111);
        run_vecs(6, 16'd6, -1);
        wait_done("t6_done");
`ifdef HALT_ON_ERR_EN
        check("t6_pass", {16'd0, pass_cnt}, 32'd2);
`else
        check("t6_pass", {16'd0, pass_cnt}, 32'd5);
`endif
        check("t6_err", {16'd0, err_cnt}, 32'd1);
        check("t6_idx", {16'd0, first_err_idx}, 32'd2);
        check("t6_z", {29'd0, first_err_z}, 32'b011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
